// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: width, funct3 encodings
// and FSM states.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, one radix-2 step per cycle,
// fixed 34-cycle latency from start to the done pulse that writes the register file.
module mul_div_unit import mdu_pkg::*; #(
  parameter int unsigned XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CntW = $clog2(XLEN);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          tag_q, tag_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic [XLEN-1:0]     opb_q, opb_d;   // multiplicand (MUL*) or divisor (DIV*/REM*) magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;   // product, or {remainder, quotient}
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       mul_sum, trial, diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, fix_res;

  assign a_sgn = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  assign b_sgn = op inside {OpMulh, OpDiv, OpRem};
  assign abs_a = (a_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs_b = (b_sgn && rs2[XLEN-1]) ? -rs2 : rs2;

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring division: the shifted partial remainder needs XLEN+1 bits before the subtract.
  assign trial    = acc_q[2*XLEN-1:XLEN-1];
  assign diff     = trial - {1'b0, opb_q};
  assign div_next = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    // A zero divisor yields an all-ones quotient with no sign flip.
    quo  = ((neg_a_q ^ neg_b_q) && (opb_q != '0)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OpMul:                     fix_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = quo;
      default:                   fix_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          tag_d   = rd_in;
          neg_a_d = a_sgn & rs1[XLEN-1];
          neg_b_d = b_sgn & rs2[XLEN-1];
          if (op[2]) begin
            acc_d = {{XLEN{1'b0}}, abs_a};
            opb_d = abs_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, abs_b};
            opb_d = abs_a;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        rd_out_d = tag_q;
        done_d   = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      tag_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model with a per-cycle compare
// process, plus directed vectors with hand-computed results.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: RV32M semantics on 64-bit integers.
  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0:    p = ua * ub;
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      3'd3:    p = ua * ub;
      3'd4:    if (b == 0) p = '1; else p = sa / sb;
      3'd5:    if (b == 0) p = '1; else p = ua / ub;
      3'd6:    if (b == 0) p = sa; else p = sa % sb;
      default: if (b == 0) p = ua; else p = ua % ub;
    endcase
    return (o == 3'd1 || o == 3'd2 || o == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  // Per-cycle compare against a transaction-level model of the unit.
  initial begin : compare
    bit          m_active = 1'b0;
    int          m_s = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_tag = '0;
    logic [4:0]  m_rdo = '0;
    forever begin
      @(negedge clk);
      if (m_active && cyc == m_s + 34) begin
        m_res = m_val;
        m_rdo = m_tag;
      end
      if (cyc >= 2) begin
        check("busy", 32'(busy), 32'(m_active && cyc > m_s));
        check("done", 32'(done), 32'(m_active && cyc == m_s + 34));
        check("result", result, m_res);
        check("rd_out", 32'(rd_out), 32'(m_rdo));
      end
      if (rst) begin
        m_active = 1'b0;
        m_res    = '0;
        m_rdo    = '0;
      end else if (m_active && cyc == m_s + 34) begin
        m_active = 1'b0;
      end else if (start && !m_active) begin
        m_active = 1'b1;
        m_s      = cyc;
        m_val    = model_res(op, rs1, rs2);
        m_tag    = rd_in;
      end
    end
  end

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp);
    int s;
    bit seen;
    @(posedge clk); #2;
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = tag; s = cyc;
    @(posedge clk); #2;
    // Scramble inputs so a unit that fails to latch them is caught.
    start = 1'b0; op = ~o; rs1 = $urandom; rs2 = $urandom; rd_in = ~tag;
    wait_done(seen);
    if (seen) begin
      check("latency", 32'(cyc - s), 32'd34);
      check("vec_result", result, exp);
      check("vec_tag", 32'(rd_out), 32'(tag));
    end
  endtask

  initial begin : stim
    vec_t vecs[$];
    int   s;
    bit   seen;
    vecs.push_back('{OpMul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
    vecs.push_back('{OpMulh,   32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{OpMulh,   32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF});
    vecs.push_back('{OpMulhu,  32'h80000000, 32'd2,        32'h00000001});
    vecs.push_back('{OpDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vecs.push_back('{OpRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{OpDiv,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003});
    vecs.push_back('{OpRem,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF});
    vecs.push_back('{OpDivu,   32'd100,      32'd7,        32'd14});
    vecs.push_back('{OpRemu,   32'd100,      32'd7,        32'd2});
    vecs.push_back('{OpDiv,    32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{OpRem,    32'd5,        32'd0,        32'd5});
    vecs.push_back('{OpDivu,   32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{OpRemu,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0});
    vecs.push_back('{OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{OpRem,    32'h80000000, 32'hFFFFFFFF, 32'd0});
    vecs.push_back('{OpDivu,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF});

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Back-to-back directed vectors; each also pins the reference model.
    foreach (vecs[i]) begin
      check("model_vec", model_res(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
    end

    // Second start while busy must be ignored.
    @(posedge clk); #2;
    start = 1'b1; op = OpMul; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; rd_in = 5'd3; s = cyc;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    @(posedge clk); #2;
    start = 1'b1; op = OpDivu; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9;
    @(posedge clk); #2 start = 1'b0;
    wait_done(seen);
    if (seen) begin
      check("ignore_latency", 32'(cyc - s), 32'd34);
      check("ignore_result", result, 32'hFFFFFFEB);
      check("ignore_tag", 32'(rd_out), 32'd3);
    end

    // Reset mid-operation aborts it; a fresh start two cycles later completes normally.
    @(posedge clk); #2;
    start = 1'b1; op = OpDivu; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd4; s = cyc;
    @(posedge clk); #2 start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_cycle", 32'(cyc - s), 32'd11);
    run_op(OpRemu, 32'd100, 32'd7, 5'd12, 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
